// File: rtl/lifo_stack_ctrl.sv
// Parametrised LIFO stack with PUSH/POP/PUSHPOP, flush, full/empty status and sticky error flags.
// Optional high-water-mark output hwm_o is enabled by defining LIFO_STACK_HWM_EN.
module lifo_stack_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] top_o,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              pop_valid_o,
  output logic [PTR_W-1:0]  sp_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ovf_o,
  output logic              unf_o
`ifdef LIFO_STACK_HWM_EN
  ,
  output logic [PTR_W-1:0]  hwm_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_PUSHPOP = 2'b11;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_sp;
  logic [DATA_W-1:0] r_top;
  logic [DATA_W-1:0] r_pop_data;
  logic              r_pop_valid;
  logic              r_full;
  logic              r_empty;
  logic              r_ovf;
  logic              r_unf;

  logic [PTR_W-1:0]  w_sp_nxt;
  logic [DATA_W-1:0] w_top_nxt;
  logic [DATA_W-1:0] w_pd_nxt;
  logic              w_pv_nxt;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic              w_full;
  logic              w_empty;

  assign w_full  = (r_sp == PTR_W'(DEPTH));
  assign w_empty = (r_sp == '0);

  // Next-state decode; flush overrides any op on the same edge.
  always_comb begin
    w_sp_nxt  = r_sp;
    w_top_nxt = r_top;
    w_pd_nxt  = r_pop_data;
    w_pv_nxt  = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    w_we      = 1'b0;
    w_waddr   = IDX_W'(r_sp);
    if (flush_i) begin
      w_sp_nxt  = '0;
      w_top_nxt = '0;
    end else begin
      case (op_i)
        OP_PUSH: begin
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_waddr   = IDX_W'(r_sp);
            w_sp_nxt  = r_sp + PTR_W'(1);
            w_top_nxt = data_i;
          end
        end
        OP_POP: begin
          if (w_empty) begin
            w_unf_set = 1'b1;
          end else begin
            w_pd_nxt  = r_top;
            w_pv_nxt  = 1'b1;
            w_sp_nxt  = r_sp - PTR_W'(1);
            w_top_nxt = (r_sp == PTR_W'(1)) ? '0 : r_mem[IDX_W'(r_sp - PTR_W'(2))];
          end
        end
        OP_PUSHPOP: begin
          // On an empty stack this degenerates to a plain push.
          if (w_empty) begin
            w_we      = 1'b1;
            w_waddr   = IDX_W'(r_sp);
            w_sp_nxt  = r_sp + PTR_W'(1);
            w_top_nxt = data_i;
          end else begin
            w_pd_nxt  = r_top;
            w_pv_nxt  = 1'b1;
            w_we      = 1'b1;
            w_waddr   = IDX_W'(r_sp - PTR_W'(1));
            w_top_nxt = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (w_we && rst_n) r_mem[w_waddr] <= data_i;
  end

  // Control/status registers; error set wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp        <= '0;
      r_top       <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_sp        <= w_sp_nxt;
      r_top       <= w_top_nxt;
      r_pop_data  <= w_pd_nxt;
      r_pop_valid <= w_pv_nxt;
      r_full      <= (w_sp_nxt == PTR_W'(DEPTH));
      r_empty     <= (w_sp_nxt == '0);
      r_ovf       <= (r_ovf & ~err_clr_i) | w_ovf_set;
      r_unf       <= (r_unf & ~err_clr_i) | w_unf_set;
    end
  end

  assign top_o       = r_top;
  assign pop_data_o  = r_pop_data;
  assign pop_valid_o = r_pop_valid;
  assign sp_o        = r_sp;
  assign full_o      = r_full;
  assign empty_o     = r_empty;
  assign ovf_o       = r_ovf;
  assign unf_o       = r_unf;

`ifdef LIFO_STACK_HWM_EN
  logic [PTR_W-1:0] r_hwm;

  // Tracks registered sp, so it lags an sp increase by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hwm <= '0;
    end else if (err_clr_i) begin
      r_hwm <= r_sp;
    end else if (r_sp > r_hwm) begin
      r_hwm <= r_sp;
    end
  end

  assign hwm_o = r_hwm;
`endif

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Scoreboarded directed bench for lifo_stack_ctrl (DATA_W=8, DEPTH=4).
module tb_lifo_stack_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH) + 1;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] PSH = 2'b01;
  localparam logic [1:0] POP = 2'b10;
  localparam logic [1:0] PP  = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        op_i = NOP;
  logic [DATA_W-1:0] data_i = '0;
  logic              flush_i = 1'b0;
  logic              err_clr_i = 1'b0;
  logic [DATA_W-1:0] top_o;
  logic [DATA_W-1:0] pop_data_o;
  logic              pop_valid_o;
  logic [PTR_W-1:0]  sp_o;
  logic              full_o;
  logic              empty_o;
  logic              ovf_o;
  logic              unf_o;
`ifdef LIFO_STACK_HWM_EN
  logic [PTR_W-1:0]  hwm_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q [$];

  lifo_stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .op_i(op_i), .data_i(data_i),
    .flush_i(flush_i), .err_clr_i(err_clr_i), .top_o(top_o),
    .pop_data_o(pop_data_o), .pop_valid_o(pop_valid_o), .sp_o(sp_o),
    .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o), .unf_o(unf_o)
`ifdef LIFO_STACK_HWM_EN
    , .hwm_o(hwm_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop strobe must match the oldest expected pop word.
  always @(negedge clk) begin
    if (rst_n && pop_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no pop", pop_data_o);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (pop_data_o !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", pop_data_o, e);
        end
      end
    end
  end

  task automatic check_state(input string tag, input int esp, input logic [7:0] etop,
                             input logic epv, input logic eovf, input logic eunf);
    chk({tag, ".sp"},    32'(sp_o),        32'(esp));
    chk({tag, ".top"},   32'(top_o),       32'(etop));
    chk({tag, ".full"},  32'(full_o),      32'(esp == int'(DEPTH)));
    chk({tag, ".empty"}, 32'(empty_o),     32'(esp == 0));
    chk({tag, ".pv"},    32'(pop_valid_o), 32'(epv));
    chk({tag, ".ovf"},   32'(ovf_o),       32'(eovf));
    chk({tag, ".unf"},   32'(unf_o),       32'(eunf));
  endtask

  // Apply one op for one edge, queue any expected pop word, then check state.
  task automatic step(input string tag, input logic [1:0] op, input logic [7:0] d,
                      input logic fl, input logic clr, input int esp, input logic [7:0] etop,
                      input logic epv, input logic [7:0] epd, input logic eovf, input logic eunf);
    op_i = op; data_i = d; flush_i = fl; err_clr_i = clr;
    if (epv) exp_q.push_back(epd);
    @(posedge clk); #1;
    op_i = NOP; flush_i = 1'b0; err_clr_i = 1'b0;
    check_state(tag, esp, etop, epv, eovf, eunf);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check_state("reset", 0, 8'h00, 0, 0, 0);
`ifdef LIFO_STACK_HWM_EN
    chk("hwm.reset", 32'(hwm_o), 32'd0);
`endif
    step("nop",     NOP, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    step("push1",   PSH, 8'hFA, 0, 0, 1, 8'hFA, 0, 8'h00, 0, 0);
    step("push2",   PSH, 8'hEF, 0, 0, 2, 8'hEF, 0, 8'h00, 0, 0);
    step("push3",   PSH, 8'h11, 0, 0, 3, 8'h11, 0, 8'h00, 0, 0);
    step("push4",   PSH, 8'h22, 0, 0, 4, 8'h22, 0, 8'h00, 0, 0);
    step("push_ov", PSH, 8'h33, 0, 0, 4, 8'h22, 0, 8'h00, 1, 0);
`ifdef LIFO_STACK_HWM_EN
    chk("hwm.full", 32'(hwm_o), 32'd4);
`endif
    step("pop1",    POP, 8'h00, 0, 0, 3, 8'h11, 1, 8'h22, 1, 0);
    step("pop2",    POP, 8'h00, 0, 0, 2, 8'hEF, 1, 8'h11, 1, 0);
    step("pop3",    POP, 8'h00, 0, 0, 1, 8'hFA, 1, 8'hEF, 1, 0);
    step("pop4",    POP, 8'h00, 0, 0, 0, 8'h00, 1, 8'hFA, 1, 0);
    step("pop_un",  POP, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1);
    step("push5a",  PSH, 8'h5A, 0, 0, 1, 8'h5A, 0, 8'h00, 1, 1);
    step("pp_a5",   PP,  8'hA5, 0, 0, 1, 8'hA5, 1, 8'h5A, 1, 1);
    step("push01",  PSH, 8'h01, 0, 0, 2, 8'h01, 0, 8'h00, 1, 1);
    step("push02",  PSH, 8'h02, 0, 0, 3, 8'h02, 0, 8'h00, 1, 1);
    step("push03",  PSH, 8'h03, 0, 0, 4, 8'h03, 0, 8'h00, 1, 1);
    step("pp_full", PP,  8'h77, 0, 0, 4, 8'h77, 1, 8'h03, 1, 1);
    step("pop_77",  POP, 8'h00, 0, 0, 3, 8'h02, 1, 8'h77, 1, 1);
    step("flush",   PSH, 8'h99, 1, 0, 0, 8'h00, 0, 8'h00, 1, 1);
    step("errclr",  NOP, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
    step("pp_empty",PP,  8'h3C, 0, 0, 1, 8'h3C, 0, 8'h00, 0, 0);
    step("pop_3c",  POP, 8'h00, 0, 0, 0, 8'h00, 1, 8'h3C, 0, 0);
    step("set_win", POP, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1);
    step("errclr2", NOP, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0);
    step("push10",  PSH, 8'h10, 0, 0, 1, 8'h10, 0, 8'h00, 0, 0);
    step("pop_10",  POP, 8'h00, 0, 0, 0, 8'h00, 1, 8'h10, 0, 0);
    step("push20",  PSH, 8'h20, 0, 0, 1, 8'h20, 0, 8'h00, 0, 0);
    step("push30",  PSH, 8'h30, 0, 0, 2, 8'h30, 0, 8'h00, 0, 0);

    // Async reset mid push sequence, between clock edges.
    op_i = PSH; data_i = 8'h40;
    #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", 0, 8'h00, 0, 0, 0);
    chk("async_rst.pd", 32'(pop_data_o), 32'd0);
`ifdef LIFO_STACK_HWM_EN
    chk("hwm.rst", 32'(hwm_o), 32'd0);
`endif
    @(posedge clk); #1;
    check_state("rst_held", 0, 8'h00, 0, 0, 0);
    op_i = NOP;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step("push44",  PSH, 8'h44, 0, 0, 1, 8'h44, 0, 8'h00, 0, 0);
    step("push55",  PSH, 8'h55, 0, 0, 2, 8'h55, 0, 8'h00, 0, 0);
    step("pop_55",  POP, 8'h00, 0, 0, 1, 8'h44, 1, 8'h55, 0, 0);
    step("nop_end", NOP, 8'h00, 0, 0, 1, 8'h44, 0, 8'h00, 0, 0);

    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
